// File: rtl/wb_select_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_select_seq_if
// Brief    : Request/response bundle between a write-back requester and
//            wb_select_seq (sources in, register-bank write port out).
// Revision : 1.0 - initial release
// ============================================================================
interface wb_select_seq_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 4
);
  logic                     start;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     err_clr;
  logic [WIDTH-1:0]         wb_data;
  logic                     wb_valid;
  logic                     busy;
  logic                     sel_err;
  logic                     to_err;

  modport master (
    output start, sel, src_data, src_ready, err_clr,
    input  wb_data, wb_valid, busy, sel_err, to_err
  );

  modport slave (
    input  start, sel, src_data, src_ready, err_clr,
    output wb_data, wb_valid, busy, sel_err, to_err
  );
endinterface
`default_nettype wire

// File: rtl/wb_select_seq.sv
`default_nettype none
// ============================================================================
// Module   : wb_select_seq
// Brief    : Write-back source sequencer: picks a source or constant channel,
//            waits for readiness, issues registered data plus a 1-cycle strobe.
//            Optional macro WB_TIMEOUT_EN enables the WAIT timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module wb_select_seq #(
  parameter int WIDTH       = 32,
  parameter int NUM_SRC     = 8,
  parameter int SEL_W       = 4,
  parameter int CONST_VAL   = 227,
  parameter int TIMEOUT_CYC = 16
) (
  input  wire             clk,
  input  wire             reset,
  wb_select_seq_if.slave  bus
);

  if ((2**SEL_W <= NUM_SRC) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("wb_select_seq: need 2**SEL_W > NUM_SRC and TIMEOUT_CYC >= 1");
  end

  localparam logic [WIDTH-1:0] c_const   = WIDTH'(CONST_VAL);
  localparam logic [SEL_W-1:0] c_num_src = SEL_W'(NUM_SRC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel_q;
  logic [WIDTH-1:0] r_wb_data, w_wb_data_nxt;
  logic             r_sel_err, w_sel_err_nxt;
  logic [SEL_W-1:0] w_idx;
  logic             w_rdy;
  logic [WIDTH-1:0] w_src;
  logic             w_sel_bad, w_sel_const;
  logic             w_timeout;

  assign w_sel_bad   = (bus.sel >  c_num_src);
  assign w_sel_const = (bus.sel == c_num_src);

  // In IDLE the live select drives the mux; afterwards the latched copy does.
  assign w_idx = (r_state == ST_IDLE) ? bus.sel : r_sel_q;

  always_comb begin
    w_rdy = 1'b0;
    w_src = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_idx == SEL_W'(i)) begin
        w_rdy = bus.src_ready[i];
        w_src = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);

  logic [c_cnt_w-1:0] r_cnt, w_cnt_inc;
  logic               r_to_err;

  assign w_cnt_inc = (r_cnt == c_cnt_w'(TIMEOUT_CYC)) ? r_cnt : r_cnt + c_cnt_w'(1);
  // Ready on the edge the count would reach the limit takes priority.
  assign w_timeout = (r_state == ST_WAIT) && !w_rdy && (w_cnt_inc == c_cnt_w'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_to_err <= 1'b0;
    end else begin
      if (r_state == ST_WAIT) begin
        r_cnt <= w_cnt_inc;
      end else begin
        r_cnt <= '0;
      end
      if (w_timeout) begin
        r_to_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_to_err <= 1'b0;
      end
    end
  end

  assign bus.to_err = r_to_err;
`else
  assign w_timeout  = 1'b0;
  assign bus.to_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_wb_data_nxt = r_wb_data;
    w_sel_err_nxt = r_sel_err & ~bus.err_clr;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_sel_bad) begin
            w_sel_err_nxt = 1'b1;
          end else if (w_sel_const) begin
            w_wb_data_nxt = c_const;
            w_state_nxt   = ST_DONE;
          end else if (w_rdy) begin
            w_wb_data_nxt = w_src;
            w_state_nxt   = ST_DONE;
          end else begin
            w_state_nxt   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_rdy) begin
          w_wb_data_nxt = w_src;
          w_state_nxt   = ST_DONE;
        end else if (w_timeout) begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_sel_q   <= '0;
      r_wb_data <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_sel_err <= w_sel_err_nxt;
      if ((r_state == ST_IDLE) && bus.start) begin
        r_sel_q <= bus.sel;
      end
    end
  end

  assign bus.wb_data  = r_wb_data;
  assign bus.wb_valid = (r_state == ST_DONE);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.sel_err  = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_select_seq
// Brief    : Randomized transaction-level bench for wb_select_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_select_seq;

  localparam int WIDTH       = 32;
  localparam int NUM_SRC     = 8;
  localparam int SEL_W       = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam logic [31:0] C_CONST = 32'h0000_00E3;

  logic clk;
  logic reset;

  wb_select_seq_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

  wb_select_seq #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
    .CONST_VAL(227), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] chan [NUM_SRC];
  logic [31:0] exp_data;
  logic        exp_sel_err;
  logic        exp_to_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // New random data on every channel; channel s gets the requested ready level.
  task automatic drive_srcs(input int s, input bit rdy_s, input bit fix,
                            input logic [31:0] fixv, input bit quiet);
    for (int i = 0; i < NUM_SRC; i++) chan[i] = $urandom;
    bus.src_ready = quiet ? 8'h00 : 8'($urandom);
    if (s < NUM_SRC) begin
      if (fix) chan[s] = fixv;
      bus.src_ready[s] = rdy_s;
    end
    for (int i = 0; i < NUM_SRC; i++) bus.src_data[i*WIDTH +: WIDTH] = chan[i];
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".sel_err"}, {31'd0, bus.sel_err}, {31'd0, exp_sel_err});
    check({tag, ".to_err"},  {31'd0, bus.to_err},  {31'd0, exp_to_err});
  endtask

  // Request on sel s whose ready line first rises d edges after the start edge.
  task automatic run_req(input int s, input int d, input bit fix,
                         input logic [31:0] fixv, input bit quiet);
    logic [31:0] expd;
    bit          is_const;
    bit          tmo;
    int          last;
    is_const = (s == NUM_SRC);
    if (is_const) d = 0;
    tmo = 1'b0;
`ifdef WB_TIMEOUT_EN
    tmo = (d > TIMEOUT_CYC);
`endif
    last = tmo ? TIMEOUT_CYC : d + 1;
    expd = exp_data;
    bus.start   = 1'b1;
    bus.sel     = 4'(s);
    bus.err_clr = 1'b0;
    for (int k = 0; k <= last; k++) begin
      drive_srcs(s, (k >= d), fix, fixv, quiet);
      if (k == d && !tmo) begin
        if (is_const) expd = C_CONST;
        else          expd = chan[s];
      end
      @(posedge clk);
      #1;
      bus.start = (k < last) ? 1'($urandom) : 1'b0;
      bus.sel   = 4'($urandom);
      if (tmo && k == last) begin
        exp_to_err = 1'b1;
        check("tmo.busy",  {31'd0, bus.busy},     32'd0);
        check("tmo.valid", {31'd0, bus.wb_valid}, 32'd0);
        check("tmo.data",  bus.wb_data,           exp_data);
      end else if (k < d) begin
        check("wait.busy",  {31'd0, bus.busy},     32'd1);
        check("wait.valid", {31'd0, bus.wb_valid}, 32'd0);
        check("wait.data",  bus.wb_data,           exp_data);
      end else if (k == d) begin
        exp_data = expd;
        check("done.busy",  {31'd0, bus.busy},     32'd1);
        check("done.valid", {31'd0, bus.wb_valid}, 32'd1);
        check("done.data",  bus.wb_data,           exp_data);
      end else begin
        check("end.busy",  {31'd0, bus.busy},     32'd0);
        check("end.valid", {31'd0, bus.wb_valid}, 32'd0);
        check("end.data",  bus.wb_data,           exp_data);
      end
      check_flags("req");
    end
  endtask

  task automatic run_bad(input int s, input bit clr);
    bus.start   = 1'b1;
    bus.sel     = 4'(s);
    bus.err_clr = clr;
    drive_srcs(NUM_SRC, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.err_clr = 1'b0;
    exp_sel_err = 1'b1;
    if (clr) exp_to_err = 1'b0;
    check("bad.busy",  {31'd0, bus.busy},     32'd0);
    check("bad.valid", {31'd0, bus.wb_valid}, 32'd0);
    check("bad.data",  bus.wb_data,           exp_data);
    check_flags("bad");
  endtask

  task automatic clr_only();
    bus.start   = 1'b0;
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    exp_sel_err = 1'b0;
    exp_to_err  = 1'b0;
    check("clr.busy", {31'd0, bus.busy}, 32'd0);
    check_flags("clr");
  endtask

  initial begin
    int r;
    int d;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.sel       = '0;
    bus.err_clr   = 1'b0;
    bus.src_ready = '0;
    bus.src_data  = '0;
    exp_data      = 32'd0;
    exp_sel_err   = 1'b0;
    exp_to_err    = 1'b0;

    #2;
    check("rst.data",  bus.wb_data,           32'd0);
    check("rst.valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst.busy",  {31'd0, bus.busy},     32'd0);
    check_flags("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_req(2, 0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check("t1.data", bus.wb_data, 32'hDEAD_BEEF);
    run_req(NUM_SRC, 0, 1'b0, 32'd0, 1'b1);
    check("t2.data", bus.wb_data, 32'h0000_00E3);
    run_req(3, 5, 1'b1, 32'h1234_5678, 1'b0);
    check("t3.data", bus.wb_data, 32'h1234_5678);

    run_bad(15, 1'b0);
    clr_only();
    run_bad(15, 1'b0);
    run_bad(9, 1'b1);

`ifdef WB_TIMEOUT_EN
    run_req(1, TIMEOUT_CYC + 1, 1'b0, 32'd0, 1'b0);
    clr_only();
    run_req(1, TIMEOUT_CYC, 1'b0, 32'd0, 1'b0);
`else
    run_req(1, TIMEOUT_CYC + 4, 1'b0, 32'd0, 1'b0);
`endif

    // Asynchronous reset in the middle of a WAIT on sel 5.
    bus.start = 1'b1;
    bus.sel   = 4'd5;
    drive_srcs(5, 1'b0, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_srcs(5, 1'b0, 1'b0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      check("prerst.busy", {31'd0, bus.busy}, 32'd1);
    end
    #2;
    reset = 1'b0;
    #1;
    exp_data    = 32'd0;
    exp_sel_err = 1'b0;
    exp_to_err  = 1'b0;
    check("arst.data",  bus.wb_data,           32'd0);
    check("arst.valid", {31'd0, bus.wb_valid}, 32'd0);
    check("arst.busy",  {31'd0, bus.busy},     32'd0);
    check_flags("arst");
    drive_srcs(5, 1'b1, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    check("arst.hold.valid", {31'd0, bus.wb_valid}, 32'd0);
    reset = 1'b1;
    run_req(0, 2, 1'b0, 32'd0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        run_bad($urandom_range(NUM_SRC + 1, 15), 1'($urandom));
      end else if (r == 1) begin
        run_req(NUM_SRC, 0, 1'b0, 32'd0, 1'($urandom));
      end else if (r == 2) begin
        clr_only();
      end else begin
        d = (r == 3) ? $urandom_range(TIMEOUT_CYC - 2, TIMEOUT_CYC + 2) : $urandom_range(0, 5);
        run_req($urandom_range(0, NUM_SRC - 1), d, 1'b0, 32'd0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
